// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction, write-back select and
// retired-instruction counter for the RV32I core.
module wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic [DATA_WIDTH-1:0] i_pc_plus4,
   input  logic [4:0]            i_rd,
   input  logic                  i_reg_write,
   input  logic [1:0]            i_wb_sel,
   input  logic [2:0]            i_funct3,
   output logic                  o_wen,
   output logic [4:0]            o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [CNT_WIDTH-1:0]  o_instret
);

   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   logic                  valid_q, valid_d;
   logic                  written_q, written_d;
   logic [CNT_WIDTH-1:0]  instret_q, instret_d;
   logic [DATA_WIDTH-1:0] alu_q, rdata_q, pc4_q;
   logic [4:0]            rd_q;
   logic                  reg_write_q;
   logic [1:0]            wb_sel_q;
   logic [2:0]            funct3_q;
   logic                  capture;

   assign capture = !i_flush && !i_stall;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      valid_d   = valid_q;
      written_d = written_q;
      instret_d = instret_q;
      if (i_flush) begin
         valid_d   = 1'b0;
         written_d = 1'b0;
      end else if (i_stall) begin
         // Remember a write already issued so a long stall cannot repeat it.
         if (o_wen) written_d = 1'b1;
      end else begin
         valid_d   = i_valid;
         written_d = 1'b0;
         if (i_valid) instret_d = instret_q + CNT_WIDTH'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q     <= 1'b0;
         written_q   <= 1'b0;
         instret_q   <= '0;
         alu_q       <= '0;
         rdata_q     <= '0;
         pc4_q       <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= '0;
         funct3_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         written_q <= written_d;
         instret_q <= instret_d;
         if (capture) begin
            alu_q       <= i_alu_result;
            rdata_q     <= i_mem_rdata;
            pc4_q       <= i_pc_plus4;
            rd_q        <= i_rd;
            reg_write_q <= i_reg_write;
            wb_sel_q    <= i_wb_sel;
            funct3_q    <= i_funct3;
         end
      end
   end

   // Little-endian lane select; halfword offset bit 0 is ignored.
   logic [1:0]            offset;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_data;

   assign offset    = alu_q[1:0];
   assign load_byte = rdata_q[{offset, 3'b000} +: 8];
   assign load_half = offset[1] ? rdata_q[31:16] : rdata_q[15:0];

   always_comb begin
      load_data = rdata_q;
      case (funct3_q)
         3'b000:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b001:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_data = rdata_q;
      endcase
   end

   always_comb begin
      o_wdata = alu_q;
      case (wb_sel_q)
         WB_LOAD: o_wdata = load_data;
         WB_PC4:  o_wdata = pc4_q;
         default: o_wdata = alu_q;
      endcase
   end

   assign o_wen     = valid_q && reg_write_q && (rd_q != 5'd0) && !written_q;
   assign o_waddr   = rd_q;
   assign o_instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expectations are queued at drive time and
// compared one cycle later when the WB outputs appear.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, stall, flush, reg_write;
   logic [31:0] alu, rdata, pc4;
   logic [4:0]  rd;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;

   logic        o_wen, o_wen4;
   logic [4:0]  o_waddr, o_waddr4;
   logic [31:0] o_wdata, o_wdata4;
   logic [63:0] o_instret;
   logic [3:0]  o_instret4;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
      .i_alu_result(alu), .i_mem_rdata(rdata), .i_pc_plus4(pc4), .i_rd(rd),
      .i_reg_write(reg_write), .i_wb_sel(wb_sel), .i_funct3(funct3),
      .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_instret(o_instret)
   );

   wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
      .i_alu_result(alu), .i_mem_rdata(rdata), .i_pc_plus4(pc4), .i_rd(rd),
      .i_reg_write(reg_write), .i_wb_sel(wb_sel), .i_funct3(funct3),
      .o_wen(o_wen4), .o_waddr(o_waddr4), .o_wdata(o_wdata4), .o_instret(o_instret4)
   );

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [63:0] instret;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] want;
   } ld_t;

   exp_t        sb[$];
   exp_t        e;
   logic [63:0] model_instret = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   ld_t ld_tbl [10] = '{
      '{3'b000, 2'd3, 32'hFFFF_FF80}, '{3'b100, 2'd3, 32'h0000_0080},
      '{3'b000, 2'd0, 32'h0000_0001}, '{3'b001, 2'd2, 32'hFFFF_80FF},
      '{3'b101, 2'd0, 32'h0000_7F01}, '{3'b010, 2'd1, 32'h80FF_7F01},
      '{3'b001, 2'd3, 32'hFFFF_80FF}, '{3'b100, 2'd1, 32'h0000_007F},
      '{3'b000, 2'd2, 32'hFFFF_FFFF}, '{3'b111, 2'd2, 32'h80FF_7F01}
   };

   // Drive one MEM-stage cycle, queue the expected WB outputs, then advance past the edge.
   task automatic drive(input logic v, input logic [4:0] r, input logic rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] md,
                        input logic [31:0] p4, input logic st, input logic fl,
                        input logic ew, input logic [4:0] ea, input logic [31:0] ed);
      @(negedge clk);
      valid = v; rd = r; reg_write = rw; wb_sel = sel; funct3 = f3;
      alu = a; rdata = md; pc4 = p4; stall = st; flush = fl;
      if (v && !st && !fl) model_instret = model_instret + 64'd1;
      sb.push_back('{ew, ea, ed, model_instret});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 0; stall = 0; flush = 0; reg_write = 0;
      alu = 0; rdata = 0; pc4 = 0; rd = 0; wb_sel = 0; funct3 = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (o_wen !== 1'b0 || o_waddr !== 5'd0 || o_wdata !== 32'd0 || o_instret !== 64'd0 ||
          o_instret4 !== 4'd0) begin
         n_fail++;
         $display("FAIL reset: got wen=%b waddr=%0d wdata=%h instret=%0d instret4=%0d, want all zero",
                  o_wen, o_waddr, o_wdata, o_instret, o_instret4);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_wen !== 1'b0 || o_instret !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got wen=%b instret=%0d, want wen=0 instret=0", o_wen, o_instret);
      end
   endtask

   task automatic test_alu();
      logic [4:0]  r;
      logic [1:0]  sel;
      logic [31:0] a, p4, want;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            r = 5'd5; sel = 2'b00; a = 32'h1234_5678; p4 = 32'h0;
         end else begin
            r = 5'($urandom_range(1, 31));
            sel = (i % 3 == 0) ? 2'b11 : ((i % 3 == 1) ? 2'b00 : 2'b10);
            a = $urandom; p4 = $urandom;
         end
         want = (sel == 2'b10) ? p4 : a;
         drive(1, r, 1, sel, 3'b010, a, 32'hCAFE_F00D, p4, 0, 0, 1, r, want);
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL alu[%0d]: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
         end
      end
   endtask

   task automatic test_loads();
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'd3, 1, 2'b01, ld_tbl[i].f3, {30'h0400_0000, ld_tbl[i].off}, 32'h80FF_7F01,
               32'h0, 0, 0, 1, 5'd3, ld_tbl[i].want);
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL load[%0d] f3=%b off=%0d: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, ld_tbl[i].f3, ld_tbl[i].off, o_wen, o_waddr, o_wdata, o_instret,
                     e.wen, e.waddr, e.wdata, e.instret);
         end
      end
   endtask

   task automatic test_x0_jal();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1, 5'd0, 1, 2'b00, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5'd0, 32'hDEAD_BEEF);
            1: drive(1, 5'd4, 0, 2'b00, 0, 32'h0000_0044, 0, 0, 0, 0, 0, 5'd4, 32'h0000_0044);
            2: drive(0, 5'd4, 1, 2'b00, 0, 32'h0000_0055, 0, 0, 0, 0, 0, 5'd4, 32'h0000_0055);
            default: drive(1, 5'd1, 1, 2'b10, 0, 32'h0000_0055, 0, 32'h0000_0104, 0, 0, 1, 5'd1, 32'h0000_0104);
         endcase
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL x0_jal[%0d]: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(1, 5'd7, 1, 2'b00, 0, 32'hA5A5_A5A5, 0, 0, 0, 0, 1, 5'd7, 32'hA5A5_A5A5);
            1, 2, 3: drive(1, 5'd9, 1, 2'b00, 0, 32'h1111_1111, 0, 0, 1, 0, 0, 5'd7, 32'hA5A5_A5A5);
            4: drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
            default: drive(1, 5'd8, 1, 2'b00, 0, 32'h0000_0888, 0, 0, 0, 0, 1, 5'd8, 32'h0000_0888);
         endcase
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL stall[%0d]: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1, 5'd6, 1, 2'b00, 0, 32'h0000_0066, 0, 0, 0, 0, 1, 5'd6, 32'h0000_0066);
            1: drive(1, 5'd12, 1, 2'b00, 0, 32'h0000_0CCC, 0, 0, 1, 1, 0, 5'd6, 32'h0000_0066);
            2: drive(1, 5'd13, 1, 2'b00, 0, 32'h0000_0DDD, 0, 0, 0, 1, 0, 5'd6, 32'h0000_0066);
            3: drive(1, 5'd14, 1, 2'b00, 0, 32'h0000_0EEE, 0, 0, 1, 0, 0, 5'd6, 32'h0000_0066);
            default: drive(1, 5'd15, 1, 2'b00, 0, 32'h0000_0FFF, 0, 0, 0, 0, 1, 5'd15, 32'h0000_0FFF);
         endcase
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL flush[%0d]: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1, 5'd10, 1, 2'b00, 0, 32'h0000_0AAA, 0, 0, 0, 0, 1, 5'd10, 32'h0000_0AAA);
      e = sb.pop_front();
      n_checks++;
      if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
         n_fail++;
         $display("FAIL async_pre: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                  o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
      end
      #2 rst_n = 1'b0;
      #1;
      model_instret = '0;
      n_checks++;
      if (o_wen !== 1'b0 || o_waddr !== 5'd0 || o_wdata !== 32'd0 || o_instret !== 64'd0 ||
          o_instret4 !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset: got wen=%b waddr=%0d wdata=%h instret=%0d instret4=%0d, want all zero",
                  o_wen, o_waddr, o_wdata, o_instret, o_instret4);
      end
      @(negedge clk);
      valid = 0; stall = 0; flush = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      logic [4:0] r;
      for (int i = 0; i < 17; i++) begin
         r = 5'((i % 31) + 1);
         drive(1, r, 1, 2'b00, 0, 32'(i), 0, 0, 0, 0, 1, r, 32'(i));
         e = sb.pop_front();
         n_checks++;
         if (o_wen !== e.wen || o_waddr !== e.waddr || o_wdata !== e.wdata || o_instret !== e.instret) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got wen=%b waddr=%0d wdata=%h instret=%0d, want wen=%b waddr=%0d wdata=%h instret=%0d",
                     i, o_wen, o_waddr, o_wdata, o_instret, e.wen, e.waddr, e.wdata, e.instret);
         end
      end
      n_checks++;
      if (o_instret4 !== 4'd1) begin
         n_fail++;
         $display("FAIL wrap_cnt4: got instret=%0d, want 1", o_instret4);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_x0_jal();
      test_stall();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic for the RV32I core.
- Captures MEM-stage results, performs load byte/half extraction and sign/zero extension, and selects the write-back source.
- Drives the register file write port (waddr/wdata/wen) directly.
- Maintains a retired-instruction counter for debug/CSR use.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 supported (load extraction is RV32-specific).
- CNT_WIDTH, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  MEM stage holds a real instruction.
- i_stall  in  1  hold WB register contents this cycle.
- i_flush  in  1  insert bubble into WB register this cycle.
- i_alu_result  in  DATA_WIDTH  ALU result / load effective address.
- i_mem_rdata  in  DATA_WIDTH  raw aligned word read from data memory.
- i_pc_plus4  in  DATA_WIDTH  link value for JAL/JALR.
- i_rd  in  5  destination register.
- i_reg_write  in  1  instruction writes rd.
- i_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- i_funct3  in  3  load type.
- o_wen  out  1  register file write enable.
- o_waddr  out  5  register file write address.
- o_wdata  out  DATA_WIDTH  register file write data.
- o_instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (i_rst_n low, async): wb_valid=0, all latched fields=0, written flag=0, o_instret=0. Hence o_wen=0, o_waddr=0, o_wdata=0.
- Capture on rising clk, in priority order:
  - i_flush=1: wb_valid<=0; other fields don't-care but are held. Flush beats stall.
  - else i_stall=1: all WB registers hold.
  - else: latch i_valid, i_alu_result, i_mem_rdata, i_pc_plus4, i_rd, i_reg_write, i_wb_sel, i_funct3.
- Latency: one cycle from MEM inputs to regfile write outputs. Outputs are combinational from WB registers.
- Written flag:
  - Cleared on every new capture and on flush.
  - Set on the edge after a cycle with o_wen=1 while i_stall=1.
  - Guarantees one write per instruction even under a multi-cycle stall.
- o_wen = wb_valid & wb_reg_write & (wb_rd != 0) & !written. Writes to x0 are never issued.
- o_waddr = wb_rd. o_wdata = selected result, computed even when o_wen=0.
- Load extraction uses offset = wb_alu_result[1:0]:
  - 000 LB: byte[offset], sign-extended.
  - 100 LBU: byte[offset], zero-extended.
  - 001 LH: half[offset[1]], sign-extended; offset[0] ignored.
  - 101 LHU: half[offset[1]], zero-extended; offset[0] ignored.
  - 010 LW and 011/110/111: full word; offset ignored.
  - Byte lanes are little-endian: byte0 = bits 7:0.
- o_instret increments by 1 on each edge that captures i_valid=1 with i_flush=0 and i_stall=0.
  - Stalled or flushed cycles never increment.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
- Reset mid-operation: an in-flight write is dropped and o_wen falls immediately (async).

Test Plan:
- Reset then ALU write: i_valid=1, rd=5, wb_sel=00, alu=0x1234_5678, reg_write=1 -> next cycle o_wen=1, o_waddr=5, o_wdata=0x12345678, o_instret=1.
- Loads with mem_rdata=0x80FF_7F01:
  - LB off=3 -> 0xFFFFFF80; LBU off=3 -> 0x00000080; LB off=0 -> 0x00000001.
  - LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01; LW -> 0x80FF7F01.
- x0 and non-writing: rd=0 with reg_write=1 -> o_wen=0. JAL with pc_plus4=0x104, rd=1, wb_sel=10 -> o_wdata=0x104, o_wen=1.
- Stall: capture rd=7, then hold i_stall=1 for 3 cycles -> o_wen high only in the first cycle, o_waddr=7 held throughout, o_instret +1 total.
- Flush and stall both high with valid input -> wb_valid=0, o_wen=0, o_instret unchanged.
- Async reset: assert i_rst_n=0 mid-cycle while o_wen=1 -> o_wen=0 and o_instret=0 before the next clk edge.
- Counter wrap: with CNT_WIDTH=4, retire 17 instructions -> o_instret=1.
